// File: rtl/decoder_scan_sequencer.sv
// Scan sequencer for a 3-to-8 decoder: walks select codes 000..111, holding each for DWELL cycles.
// Single sweep ends with a one-cycle DONE; continuous mode wraps until stopped.
module decoder_scan_sequencer #(
  parameter int unsigned DWELL = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  input  logic mode,
  output logic dcodeing,
  output logic input2,
  output logic input1,
  output logic input0,
  output logic busy,
  output logic done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_COUNT = 8'(DWELL - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] sel_q, sel_d;
  logic       mode_q, mode_d;
  logic       en_q, en_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      mode_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      mode_q  <= mode_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // NOTE: every comb output is defaulted to its held value first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = SCAN;
          mode_d  = mode;
          cnt_d   = '0;
          sel_d   = '0;
        end
      end
      SCAN: begin
        // stop outranks the dwell/wrap event on the same edge
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
          sel_d   = '0;
        end else if (cnt_q == LAST_COUNT) begin
          cnt_d = '0;
          sel_d = sel_q + 3'd1;
          if (sel_q == 3'd7 && !mode_q) begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
        sel_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        sel_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they never glitch between edges.
  always_comb begin
    en_d   = (state_d == SCAN);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign dcodeing                 = en_q;
  assign {input2, input1, input0} = sel_q;
  assign busy                     = busy_q;
  assign done                     = done_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Self-checking bench for decoder_scan_sequencer: expected per-cycle outputs are queued
// as stimulus is planned, then popped and compared one cycle at a time.
module tb_decoder_scan_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic start_a, stop_a, mode_a;
  logic start_b, stop_b, mode_b;
  logic en_a, i2_a, i1_a, i0_a, busy_a, done_a;
  logic en_b, i2_b, i1_b, i0_b, busy_b, done_b;

  always #5 clk = ~clk;

  decoder_scan_sequencer #(.DWELL(2)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stop(stop_a), .mode(mode_a),
    .dcodeing(en_a), .input2(i2_a), .input1(i1_a), .input0(i0_a),
    .busy(busy_a), .done(done_a)
  );

  decoder_scan_sequencer #(.DWELL(1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .mode(mode_b),
    .dcodeing(en_b), .input2(i2_b), .input1(i1_b), .input0(i0_b),
    .busy(busy_b), .done(done_b)
  );

  typedef struct packed {
    logic       en;
    logic [2:0] sel;
    logic       busy;
    logic       done;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam obs_t IDLE_O = obs_t'(6'b0_000_0_0);
  localparam obs_t DONE_O = obs_t'(6'b0_000_1_1);

  function automatic obs_t scan_o(int sel);
    return obs_t'({1'b1, 3'(sel), 1'b1, 1'b0});
  endfunction

  // Downstream 3-to-8 decoder model: one-hot when enabled, all low otherwise.
  function automatic logic [7:0] decode(obs_t o);
    return o.en ? (8'b1 << o.sel) : 8'b0;
  endfunction

  function automatic obs_t obs_a();
    return obs_t'({en_a, i2_a, i1_a, i0_a, busy_a, done_a});
  endfunction

  function automatic obs_t obs_b();
    return obs_t'({en_b, i2_b, i1_b, i0_b, busy_b, done_b});
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t o;
    rst = 1'b1;
    start_a = 0; stop_a = 0; mode_a = 0;
    start_b = 0; stop_b = 0; mode_b = 0;
    next_cycle();
    next_cycle();
    o = obs_a(); n_checks++;
    if ({decode(o), o} !== {decode(IDLE_O), IDLE_O}) begin
      n_fail++;
      $display("FAIL reset_a: got en/sel/busy/done=%b required %b", o, IDLE_O);
    end
    o = obs_b(); n_checks++;
    if ({decode(o), o} !== {decode(IDLE_O), IDLE_O}) begin
      n_fail++;
      $display("FAIL reset_b: got en/sel/busy/done=%b required %b", o, IDLE_O);
    end
    rst = 1'b0;
    next_cycle();
  endtask

  // DWELL=2 single sweep; start and stop in DONE must be ignored.
  task automatic test_single_sweep();
    obs_t o, e;
    int k = 0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(scan_o(i / 2));
    exp_q.push_back(DONE_O);
    exp_q.push_back(IDLE_O);
    exp_q.push_back(IDLE_O);
    mode_a = 1'b0; start_a = 1'b1;
    next_cycle();
    start_a = 1'b0;
    while (exp_q.size() > 0) begin
      o = obs_a(); e = exp_q.pop_front(); n_checks++;
      if ({decode(o), o} !== {decode(e), e}) begin
        n_fail++;
        $display("FAIL single_sweep step %0d: got %b dec=%b required %b dec=%b", k, o, decode(o), e, decode(e));
      end
      start_a = (k == 16);
      stop_a  = (k == 16);
      k++;
      next_cycle();
    end
    start_a = 0; stop_a = 0;
  endtask

  // DWELL=2 continuous: wraps without a gap; mode change while busy ignored; stop on a dwell edge.
  task automatic test_continuous();
    obs_t o, e;
    int k = 0;
    exp_q.delete();
    for (int i = 0; i < 20; i++) exp_q.push_back(scan_o((i / 2) % 8));
    exp_q.push_back(IDLE_O);
    exp_q.push_back(IDLE_O);
    mode_a = 1'b1; start_a = 1'b1;
    next_cycle();
    start_a = 1'b0; mode_a = 1'b0;
    while (exp_q.size() > 0) begin
      o = obs_a(); e = exp_q.pop_front(); n_checks++;
      if ({decode(o), o} !== {decode(e), e}) begin
        n_fail++;
        $display("FAIL continuous step %0d: got %b dec=%b required %b dec=%b", k, o, decode(o), e, decode(e));
      end
      stop_a = (k == 19);
      k++;
      next_cycle();
    end
    stop_a = 0;
  endtask

  // DWELL=1: stop at select 011, then a later start restarts from 000 and completes.
  task automatic test_stop_dwell1();
    obs_t o, e;
    int k = 0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(scan_o(i));
    exp_q.push_back(IDLE_O);
    exp_q.push_back(IDLE_O);
    for (int i = 0; i < 8; i++) exp_q.push_back(scan_o(i));
    exp_q.push_back(DONE_O);
    exp_q.push_back(IDLE_O);
    mode_b = 1'b0; start_b = 1'b1;
    next_cycle();
    start_b = 1'b0;
    while (exp_q.size() > 0) begin
      o = obs_b(); e = exp_q.pop_front(); n_checks++;
      if ({decode(o), o} !== {decode(e), e}) begin
        n_fail++;
        $display("FAIL stop_dwell1 step %0d: got %b dec=%b required %b dec=%b", k, o, decode(o), e, decode(e));
      end
      stop_b  = (k == 3);
      start_b = (k == 5);
      k++;
      next_cycle();
    end
    start_b = 0; stop_b = 0;
  endtask

  // start+stop together in IDLE stays idle; start pulsed mid-sweep is ignored.
  task automatic test_start_while_busy();
    obs_t o, e;
    int k = 0;
    exp_q.delete();
    exp_q.push_back(IDLE_O);
    exp_q.push_back(IDLE_O);
    for (int i = 0; i < 16; i++) exp_q.push_back(scan_o(i / 2));
    exp_q.push_back(DONE_O);
    exp_q.push_back(IDLE_O);
    mode_a = 1'b0; start_a = 1'b1; stop_a = 1'b1;
    next_cycle();
    stop_a = 1'b0;
    while (exp_q.size() > 0) begin
      o = obs_a(); e = exp_q.pop_front(); n_checks++;
      if ({decode(o), o} !== {decode(e), e}) begin
        n_fail++;
        $display("FAIL start_while_busy step %0d: got %b dec=%b required %b dec=%b", k, o, decode(o), e, decode(e));
      end
      // k=0 keeps start low for one idle cycle; k=1 launches; k=6,7 hit select 010
      start_a = (k == 1) || (k == 6) || (k == 7);
      k++;
      next_cycle();
    end
    start_a = 0;
  endtask

  // Reset at select 101 aborts without done; start on the first edge out of reset is taken.
  task automatic test_reset_mid_sweep();
    obs_t o, e;
    int k = 0;
    exp_q.delete();
    for (int i = 0; i < 11; i++) exp_q.push_back(scan_o(i / 2));
    exp_q.push_back(IDLE_O);
    for (int i = 0; i < 16; i++) exp_q.push_back(scan_o(i / 2));
    exp_q.push_back(DONE_O);
    exp_q.push_back(IDLE_O);
    mode_a = 1'b0; start_a = 1'b1;
    next_cycle();
    start_a = 1'b0;
    while (exp_q.size() > 0) begin
      o = obs_a(); e = exp_q.pop_front(); n_checks++;
      if ({decode(o), o} !== {decode(e), e}) begin
        n_fail++;
        $display("FAIL reset_mid_sweep step %0d: got %b dec=%b required %b dec=%b", k, o, decode(o), e, decode(e));
      end
      rst     = (k == 10);
      start_a = (k == 10) || (k == 11);
      k++;
      next_cycle();
    end
    rst = 0; start_a = 0;
  endtask

  initial begin
    test_reset();
    test_single_sweep();
    test_continuous();
    test_stop_dwell1();
    test_start_while_busy();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_scan_sequencer.md
DECODER_SCAN_SEQUENCER -- requirements
Module: decoder_scan_sequencer

Interface
REQ-001 SHALL provide parameter DWELL, default 2, number of clock cycles each select code is held; legal range 1..255.
REQ-002 SHALL provide port clk, input, 1, single system clock; all state changes on rising edge.
REQ-003 SHALL provide port rst, input, 1, reset; reset is synchronous and active-high.
REQ-004 SHALL provide port start, input, 1, begin a sweep when sampled high in IDLE.
REQ-005 SHALL provide port stop, input, 1, abort an active sweep.
REQ-006 SHALL provide port mode, input, 1, 0 = single sweep, 1 = continuous; sampled only on the start edge.
REQ-007 SHALL provide port dcodeing, output, 1, enable to the downstream 3-to-8 decoder.
REQ-008 SHALL provide ports input2, input1, input0, outputs, 1 each, decoder select code, MSB..LSB.
REQ-009 SHALL provide port busy, output, 1, high in any state other than IDLE.
REQ-010 SHALL provide port done, output, 1, one-cycle pulse at the end of a completed single sweep.

Function
REQ-011 SHALL implement FSM states IDLE, SCAN, DONE; all outputs registered, no combinational input-to-output path.
REQ-012 IDLE: dcodeing=0, select=000, busy=0, done=0.
REQ-013 IDLE -> SCAN when start=1 and stop=0 at an edge; the mode value is latched on that edge.
REQ-014 start and stop both high in IDLE: stop wins, remain IDLE.
REQ-015 Entry to SCAN: dcodeing=1, select=000, dwell counter=0, busy=1, all visible in the cycle after the start edge (latency 1).
REQ-016 In SCAN the dwell counter (8 bit) increments each cycle; at count DWELL-1 it clears and select increments by 1, modulo 8.
REQ-017 Each select code SHALL remain stable for exactly DWELL cycles; a full sweep 000..111 spans 8*DWELL cycles.
REQ-018 Continuous mode: at the end of the dwell on 111, select wraps to 000 with no gap cycle and dcodeing stays 1.
REQ-019 Single mode: at the end of the dwell on 111, go to DONE: dcodeing=0, select=000, done=1, busy=1 for exactly one cycle.
REQ-020 DONE -> IDLE unconditionally on the next edge; start in DONE is ignored.
REQ-021 stop=1 in SCAN: next edge -> IDLE, dcodeing=0, select=000, no done pulse; stop has priority over the dwell or wrap event on the same edge.
REQ-022 start while busy is ignored; mode changes while busy have no effect.
REQ-023 stop in IDLE or DONE SHALL have no effect beyond REQ-014.
REQ-024 Select outputs SHALL change only while dcodeing=1 or on entry to IDLE/DONE; no glitch codes between edges.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, dcodeing=0, select=000, busy=0, done=0, dwell counter=0, latched mode=0, regardless of state.
REQ-026 rst has priority over start, stop and all FSM transitions; reset mid-sweep aborts without a done pulse.
REQ-027 On the first edge with rst=0 the block SHALL be in IDLE and accept start on that same edge.

Verification
REQ-028 DWELL=2, mode=0, pulse start one cycle -> dcodeing=1 for 16 cycles; select 000,000,001,001,...,111,111; then done=1 for one cycle with select=000; busy=0 afterwards.
REQ-029 DWELL=2, mode=1, start -> after 16 cycles select returns 000 with dcodeing still 1, done never asserts; stop -> dcodeing=0, select=000 one cycle later.
REQ-030 DWELL=1, mode=0, stop asserted on the cycle select=011 -> next cycle IDLE, select=000, no done pulse; a later start restarts at 000.
REQ-031 start and stop high together in IDLE -> busy stays 0; start pulsed during SCAN at select=010 -> sequence continues undisturbed to 111.
REQ-032 rst asserted during SCAN at select=101 -> all outputs 0 at the next edge; start on the first edge with rst=0 -> dcodeing=1, select=000 next cycle.
REQ-033 Bench SHALL check each (dcodeing, select) pair against a decoder model: exactly one of out0..out7 high while dcodeing=1, all low otherwise.
